pad_responder: RTL and testbench

Memory-side responder for the core's pad bus, i.e. the target end of the `pad_read` / `pad_write` / `pad_data_size` interface the core drives as initiator. It services instruction fetches and load/store traffic from a word-organised local RAM with byte-lane writes and right-justified read alignment. It also decodes a small MMIO window containing:
- a console transmit FIFO with a valid/ready drain port;
- a free-running 64-bit cycle counter.

---
 rtl/pad_responder_pkg.sv | 58 +++++
 rtl/pad_responder_fifo.sv | 65 ++++++
 rtl/pad_responder.sv | 173 +++++++++++++++++
 tb/tb_pad_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_responder_pkg.sv
// Shared definitions for the pad bus responder.
//   - Access size encodings driven by the core on pad_data_size.
//   - MMIO register offsets (address[3:2] inside the 16-byte window).
//   - STATUS bit positions for the fixed low fields. The FIFO count
//     starts at STAT_COUNT. The fault and overflow bits sit directly
//     above the count, so their positions depend on the FIFO depth.
//   - Helpers for alignment checks, read masks and write byte lanes.
package pad_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam logic [1:0] MMIO_CONSOLE  = 2'd0;
    localparam logic [1:0] MMIO_STATUS   = 2'd1;
    localparam logic [1:0] MMIO_CYCLE_LO = 2'd2;
    localparam logic [1:0] MMIO_CYCLE_HI = 2'd3;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_COUNT = 2;

    // Encoding 2'b10 is handled as a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offs);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = offs[0];
            default:   is_misaligned = (offs != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_mask = 32'h0000_00FF;
            SIZE_HALF: size_mask = 32'h0000_FFFF;
            default:   size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offs);
        case (size)
            SIZE_BYTE: lane_enable = 4'b0001 << offs;
            SIZE_HALF: lane_enable = offs[1] ? 4'b1100 : 4'b0011;
            default:   lane_enable = 4'b1111;
        endcase
    endfunction

    // Replicates right-justified write data across the lanes. The lane
    // enables then pick the lanes that actually receive the data.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SIZE_BYTE: lane_data = {4{d[7:0]}};
            SIZE_HALF: lane_data = {2{d[15:0]}};
            default:   lane_data = d;
        endcase
    endfunction

endpackage

// File: rtl/pad_responder_fifo.sv
// byte_fifo: circular byte FIFO feeding the console transmit port.
// Ports:
//   clock, reset        - single clock, synchronous active-high reset
//   push, push_data     - enqueue request and byte
//   pop                 - dequeue request (ignored while empty)
//   head                - oldest byte, 0 while empty
//   empty, full, count  - occupancy flags and entry count
// The pointers are one bit wider than the index. Full is the case where
// the index bits match and the wrap bits differ.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [7:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_pop, do_push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A pop in the same cycle frees a slot, so a push to a full FIFO is
    // still accepted. A pop from an empty FIFO never happens.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + ONE : rd_ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pad_responder.sv
// pad_responder: target end of the core's pad bus.
// This block serves a word-organised RAM with byte-lane writes and
// right-justified reads. It also decodes a 16-byte MMIO window with a
// console FIFO, a STATUS register and a 64-bit cycle counter.
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   address                - byte address of the current access
//   pad_read / pad_write   - read (same-cycle data) / write (commits at posedge)
//   pad_data_size          - 00 byte, 01 half, 11 or 10 word
//   data_out               - write data from the core
//   data_in                - read data to the core, 0 when not reading
//   tx_data, tx_valid      - console FIFO head and non-empty flag
//   tx_ready               - consumer pops the head when tx_valid is high
//   misaligned_fault       - sticky alignment fault, cleared by a STATUS write
module pad_responder
    import pad_responder_pkg::*;
#(
    parameter int          MEM_WORDS  = 4096,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        pad_read,
    input  logic        pad_write,
    input  logic [1:0]  pad_data_size,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        misaligned_fault
);

    localparam int IW            = $clog2(MEM_WORDS);
    localparam int CW            = $clog2(FIFO_DEPTH) + 1;
    localparam int STAT_FAULT    = STAT_COUNT + CW;
    localparam int STAT_OVERFLOW = STAT_FAULT + 1;
    localparam int SW            = STAT_OVERFLOW + 1;

    logic [31:0] mem_q [MEM_WORDS];

    logic          overflow_q, overflow_d;
    logic          fault_q, fault_d;
    logic [63:0]   cycle_q, cycle_d;
    logic [31:0]   cycle_hi_q, cycle_hi_d;

    logic          mmio_hit, misaligned, wr_ok, ram_we;
    logic [1:0]    mmio_off;
    logic [IW-1:0] word_idx;
    logic [31:0]   ram_word;
    logic [3:0]    lanes;
    logic [31:0]   wdata_lanes;
    logic          console_push, status_wr, lo_rd, drop;
    logic [SW-1:0] status_w;
    logic [31:0]   rd_data;

    logic          fifo_pop, fifo_empty, fifo_full;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;

    // Decode and alignment. Size still governs alignment inside the MMIO
    // window even though it does not shape the returned data there.
    assign mmio_hit    = (address[31:4] == MMIO_BASE[31:4]);
    assign mmio_off    = address[3:2];
    assign misaligned  = is_misaligned(pad_data_size, address[1:0]);
    assign word_idx    = address[IW+1:2];
    assign wr_ok       = pad_write & ~misaligned;
    assign ram_we      = wr_ok & ~mmio_hit;
    assign lanes       = lane_enable(pad_data_size, address[1:0]);
    assign wdata_lanes = lane_data(pad_data_size, data_out);
    assign ram_word    = mem_q[word_idx];

    assign console_push = wr_ok & mmio_hit & (mmio_off == MMIO_CONSOLE);
    assign status_wr    = wr_ok & mmio_hit & (mmio_off == MMIO_STATUS);
    assign lo_rd        = pad_read & ~misaligned & mmio_hit & (mmio_off == MMIO_CYCLE_LO);

    assign fifo_pop = tx_ready & ~fifo_empty;
    // A byte is lost only if the FIFO is full and nothing drains in the same cycle.
    assign drop     = console_push & fifo_full & ~fifo_pop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (console_push),
        .push_data (data_out[7:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign tx_data          = fifo_head;
    assign tx_valid         = ~fifo_empty;
    assign misaligned_fault = fault_q;

    always_comb begin
        status_w                    = '0;
        status_w[STAT_EMPTY]        = fifo_empty;
        status_w[STAT_FULL]         = fifo_full;
        status_w[STAT_COUNT +: CW]  = fifo_count;
        status_w[STAT_FAULT]        = fault_q;
        status_w[STAT_OVERFLOW]     = overflow_q;
    end

    // Combinational read path. Misaligned and idle cycles return 0.
    always_comb begin
        rd_data = '0;
        if (pad_read && !misaligned) begin
            if (mmio_hit) begin
                case (mmio_off)
                    MMIO_STATUS:   rd_data = 32'(status_w);
                    MMIO_CYCLE_LO: rd_data = cycle_q[31:0];
                    MMIO_CYCLE_HI: rd_data = cycle_hi_q;
                    default:       rd_data = '0;
                endcase
            end else begin
                rd_data = (ram_word >> {address[1:0], 3'b000}) & size_mask(pad_data_size);
            end
        end
    end

    assign data_in = rd_data;

    always_comb begin
        overflow_d = overflow_q;
        fault_d    = fault_q;
        if (status_wr) begin
            overflow_d = 1'b0;
            fault_d    = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if ((pad_read || pad_write) && misaligned) begin
            fault_d = 1'b1;
        end
        cycle_d    = cycle_q + 64'd1;
        // The latch takes the high half seen by this same read of the low half.
        // A later CYCLE_HI read then returns a consistent 64-bit pair.
        cycle_hi_d = lo_rd ? cycle_q[63:32] : cycle_hi_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
            fault_q    <= 1'b0;
            cycle_q    <= '0;
            cycle_hi_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            fault_q    <= fault_d;
            cycle_q    <= cycle_d;
            cycle_hi_q <= cycle_hi_d;
        end
    end

    // RAM contents are not reset. A write that coincides with reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_pad_responder.sv
module tb_pad_responder;
    import pad_responder_pkg::*;

    localparam int          MEM_WORDS  = 4096;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
    localparam int          MEM_BYTES  = MEM_WORDS * 4;
    localparam logic [31:0] A_CONSOLE  = MMIO_BASE;
    localparam logic [31:0] A_STATUS   = MMIO_BASE + 32'd4;
    localparam logic [31:0] A_LO       = MMIO_BASE + 32'd8;
    localparam logic [31:0] A_HI       = MMIO_BASE + 32'd12;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        pad_read;
    logic        pad_write;
    logic [1:0]  pad_data_size;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        misaligned_fault;

    always #5 clock = ~clock;

    pad_responder #(
        .MEM_WORDS  (MEM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MMIO_BASE  (MMIO_BASE)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .address          (address),
        .pad_read         (pad_read),
        .pad_write        (pad_write),
        .pad_data_size    (pad_data_size),
        .data_out         (data_out),
        .data_in          (data_in),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .misaligned_fault (misaligned_fault)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic cur_rdy = 1'b0;

    // Reference model: byte-addressed memory, a queue for the console,
    // flags and a plain 64-bit cycle count.
    logic [7:0]  m_mem [MEM_BYTES];
    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic        m_fault;
    logic [63:0] m_cycle;
    logic [31:0] m_hi;

    function automatic logic tb_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    endfunction

    function automatic int tb_nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic tb_mmio(input logic [31:0] a);
        return (a >= MMIO_BASE) && (a < MMIO_BASE + 32'd16);
    endfunction

    function automatic logic [31:0] model_status();
        int c;
        c = m_q.size();
        return (32'(m_ovf) << 7) | (32'(m_fault) << 6) | (32'(c) << 2) |
               (32'(c == FIFO_DEPTH) << 1) | 32'(c == 0);
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] r;
        int bi;
        r = 32'h0;
        if (!rd || tb_bad(sz, a)) return 32'h0;
        if (tb_mmio(a)) begin
            case (a[3:2])
                2'd1:    r = model_status();
                2'd2:    r = m_cycle[31:0];
                2'd3:    r = m_hi;
                default: r = 32'h0;
            endcase
        end else begin
            bi = int'(a % MEM_BYTES);
            for (int i = 0; i < tb_nbytes(sz); i++) r = r | (32'(m_mem[bi + i]) << (8 * i));
        end
        return r;
    endfunction

    task automatic model_update(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                                input logic [31:0] wd, input logic rdy, input logic rst);
        logic bad;
        int   bi;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0; m_fault = 1'b0; m_cycle = 64'd0; m_hi = 32'd0;
            return;
        end
        bad = tb_bad(sz, a);
        if (rd && !bad && tb_mmio(a) && a[3:2] == 2'd2) m_hi = m_cycle[63:32];
        m_cycle = m_cycle + 64'd1;
        if ((rd || wr) && bad) m_fault = 1'b1;
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (wr && !bad) begin
            if (tb_mmio(a)) begin
                if (a[3:2] == 2'd0) begin
                    if (m_q.size() < FIFO_DEPTH) m_q.push_back(wd[7:0]);
                    else m_ovf = 1'b1;
                end else if (a[3:2] == 2'd1) begin
                    m_ovf = 1'b0; m_fault = 1'b0;
                end
            end else begin
                bi = int'(a % MEM_BYTES);
                for (int i = 0; i < tb_nbytes(sz); i++) m_mem[bi + i] = wd[8*i +: 8];
            end
        end
    endtask

    function automatic logic [7:0] model_tx_data();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    // One bus cycle: drive after negedge, sample, clock, update model, return at negedge.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input logic rdy, input logic rst,
                       output logic [31:0] obs, output logic [31:0] exp);
        reset = rst; pad_read = rd; pad_write = wr; address = a;
        pad_data_size = sz; data_out = wd; tx_ready = rdy;
        #1;
        obs = data_in;
        exp = model_read(rd, a, sz);
        @(posedge clock);
        model_update(rd, wr, a, sz, wd, rdy, rst);
        @(negedge clock);
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] o, e;
        cyc(1'b0, 1'b1, a, sz, d, cur_rdy, 1'b0, o, e);
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] sz, output logic [31:0] o, output logic [31:0] e);
        cyc(1'b1, 1'b0, a, sz, 32'h0, cur_rdy, 1'b0, o, e);
    endtask

    task automatic idle();
        logic [31:0] o, e;
        cyc(1'b0, 1'b0, 32'h0, SIZE_WORD, 32'h0, cur_rdy, 1'b0, o, e);
    endtask

    task automatic test_reset();
        logic [31:0] o, e;
        cur_rdy = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 32'h0, SIZE_WORD, 32'h0, 1'b0, 1'b1, o, e);
        cyc(1'b0, 1'b0, 32'h0, SIZE_WORD, 32'h0, 1'b0, 1'b0, o, e);
        n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL reset_data_in: got %h want 00000000", o); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_checks++; if (misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", misaligned_fault); end
        rd(A_STATUS, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h want 00000001", o); end
    endtask

    task automatic test_ram_directed();
        logic [31:0] o, e;
        wr(32'h10, SIZE_WORD, 32'hDEADBEEF);
        rd(32'h13, SIZE_BYTE, o, e);
        n_checks++; if (o !== 32'h000000DE) begin n_fail++; $display("FAIL byte_rd_13: got %h want 000000DE", o); end
        rd(32'h12, SIZE_HALF, o, e);
        n_checks++; if (o !== 32'h0000DEAD) begin n_fail++; $display("FAIL half_rd_12: got %h want 0000DEAD", o); end
        cyc(1'b0, 1'b0, 32'h10, SIZE_WORD, 32'h0, 1'b0, 1'b0, o, e);
        n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL idle_data_in: got %h want 00000000", o); end
        wr(32'h11, SIZE_BYTE, 32'hFFFFFF55);
        rd(32'h10, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'hDEAD55EF) begin n_fail++; $display("FAIL byte_merge: got %h want DEAD55EF", o); end
        rd(32'h10 + 32'(MEM_BYTES * 5), SIZE_WORD, o, e);
        n_checks++; if (o !== 32'hDEAD55EF) begin n_fail++; $display("FAIL alias_rd: got %h want DEAD55EF", o); end
        rd(32'h10, 2'b10, o, e);
        n_checks++; if (o !== 32'hDEAD55EF) begin n_fail++; $display("FAIL size10_rd: got %h want DEAD55EF", o); end
        rd(32'h11, SIZE_BYTE, o, e);
        n_checks++; if (o !== 32'h00000055) begin n_fail++; $display("FAIL byte_rd_11: got %h want 00000055", o); end
    endtask

    task automatic test_misaligned();
        logic [31:0] o, e;
        wr(32'h13, SIZE_HALF, 32'h0000ABCD);
        n_checks++; if (misaligned_fault !== 1'b1) begin n_fail++; $display("FAIL mis_wr_fault: got %b want 1", misaligned_fault); end
        rd(32'h10, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'hDEAD55EF) begin n_fail++; $display("FAIL mis_wr_suppressed: got %h want DEAD55EF", o); end
        rd(32'h11, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL mis_rd_zero: got %h want 00000000", o); end
        rd(A_STATUS, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h41) begin n_fail++; $display("FAIL status_fault: got %h want 00000041", o); end
        wr(A_STATUS, SIZE_WORD, 32'h0);
        n_checks++; if (misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL status_clear: got %b want 0", misaligned_fault); end
        wr(A_STATUS + 32'd1, SIZE_HALF, 32'h0);
        n_checks++; if (misaligned_fault !== 1'b1) begin n_fail++; $display("FAIL mmio_mis_wr: got %b want 1", misaligned_fault); end
        wr(A_STATUS, SIZE_BYTE, 32'h0);
        n_checks++; if (misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL status_byte_clear: got %b want 0", misaligned_fault); end
        rd(32'h13, SIZE_BYTE, o, e);
        n_checks++; if (misaligned_fault !== 1'b0) begin n_fail++; $display("FAIL byte_no_fault: got %b want 0", misaligned_fault); end
    endtask

    task automatic test_rw_same();
        logic [31:0] o, e;
        wr(32'h20, SIZE_WORD, 32'hCAFEF00D);
        cyc(1'b1, 1'b1, 32'h20, SIZE_WORD, 32'h12345678, 1'b0, 1'b0, o, e);
        n_checks++; if (o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rw_pre_write: got %h want CAFEF00D", o); end
        rd(32'h20, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h12345678) begin n_fail++; $display("FAIL rw_post_write: got %h want 12345678", o); end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] o, e;
        cur_rdy = 1'b0;
        for (int i = 0; i < 9; i++) wr(A_CONSOLE, SIZE_WORD, 32'h41 + 32'(i));
        rd(A_STATUS, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'hA2) begin n_fail++; $display("FAIL ovf_status: got %h want 000000A2", o); end
        rd(A_CONSOLE, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL console_rd: got %h want 00000000", o); end
        cur_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                n_fail++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            idle();
        end
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL drain_empty: got v=%b d=%h want v=0 d=00", tx_valid, tx_data); end
        cur_rdy = 1'b0;
        rd(A_STATUS, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h81) begin n_fail++; $display("FAIL ovf_sticky: got %h want 00000081", o); end
        wr(A_STATUS, SIZE_WORD, 32'h0);
        rd(A_STATUS, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h01) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000001", o); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] o, e;
        logic [7:0]  x;
        cur_rdy = 1'b0;
        for (int i = 0; i < 8; i++) wr(A_CONSOLE, SIZE_WORD, 32'h60 + 32'(i));
        rd(A_STATUS, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h22) begin n_fail++; $display("FAIL full_status: got %h want 00000022", o); end
        cyc(1'b0, 1'b1, A_CONSOLE, SIZE_WORD, 32'h70, 1'b1, 1'b0, o, e);
        rd(A_STATUS, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h22) begin n_fail++; $display("FAIL full_pushpop_status: got %h want 00000022", o); end
        cur_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = (i < 7) ? 8'(8'h61 + i) : 8'h70;
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== x) begin
                n_fail++; $display("FAIL pushpop_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, x);
            end
            idle();
        end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_empty: got %b want 0", tx_valid); end
        cyc(1'b0, 1'b1, A_CONSOLE, SIZE_WORD, 32'h33, 1'b1, 1'b0, o, e);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h33) begin n_fail++; $display("FAIL empty_pushpop: got v=%b d=%h want v=1 d=33", tx_valid, tx_data); end
        cur_rdy = 1'b0;
        rd(A_STATUS, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h04) begin n_fail++; $display("FAIL empty_pushpop_status: got %h want 00000004", o); end
        cur_rdy = 1'b1;
        idle();
        cur_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] o, e;
        wr(32'h40, SIZE_WORD, 32'h01020304);
        for (int i = 0; i < 3; i++) wr(A_CONSOLE, SIZE_WORD, 32'h90 + 32'(i));
        cyc(1'b0, 1'b1, 32'h40, SIZE_WORD, 32'hFFFFFFFF, 1'b0, 1'b1, o, e);
        idle();
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_fifo: got v=%b d=%h want v=0 d=00", tx_valid, tx_data); end
        rd(32'h40, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h01020304) begin n_fail++; $display("FAIL mid_reset_write: got %h want 01020304", o); end
        rd(A_LO, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'd2) begin n_fail++; $display("FAIL mid_reset_cycle: got %0d want 2", o); end
    endtask

    task automatic test_cycle();
        logic [31:0] o, e;
        cyc(1'b0, 1'b0, 32'h0, SIZE_WORD, 32'h0, 1'b0, 1'b1, o, e);
        repeat (100) idle();
        rd(A_LO, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'd100) begin n_fail++; $display("FAIL cycle_lo_100: got %0d want 100", o); end
        rd(A_HI, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'd0) begin n_fail++; $display("FAIL cycle_hi_0: got %h want 00000000", o); end
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        rd(A_LO, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL forced_lo: got %h want FFFFFFFF", o); end
        rd(A_HI, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL forced_hi: got %h want 00000000", o); end
        force dut.cycle_q = 64'h0000_0001_0000_0005;
        rd(A_LO, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h5) begin n_fail++; $display("FAIL carry_lo: got %h want 00000005", o); end
        force dut.cycle_q = 64'h0000_0002_0000_0000;
        rd(A_HI, SIZE_WORD, o, e);
        n_checks++; if (o !== 32'h1) begin n_fail++; $display("FAIL snapshot_hi: got %h want 00000001", o); end
        release dut.cycle_q;
        cyc(1'b0, 1'b0, 32'h0, SIZE_WORD, 32'h0, 1'b0, 1'b1, o, e);
    endtask

    task automatic test_random();
        logic [31:0] o, e, a;
        logic [1:0]  sz;
        logic        r, w, rdy;
        for (int wi = 0; wi < 32; wi++) wr(32'(wi * 4), SIZE_WORD, $urandom);
        for (int n = 0; n < 600; n++) begin
            sz  = 2'($urandom_range(0, 3));
            r   = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) a = ($urandom & ~32'h0001_3FFF) | 32'($urandom_range(0, 127));
            else a = MMIO_BASE | 32'($urandom_range(0, 15));
            cyc(r, w, a, sz, $urandom, rdy, 1'b0, o, e);
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL rnd_data_in[%0d] a=%h sz=%b: got %h want %h", n, a, sz, o, e); end
            n_checks++; if (tx_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_tx_valid[%0d]: got %b want %b", n, tx_valid, m_q.size() > 0); end
            n_checks++; if (tx_data !== model_tx_data()) begin n_fail++; $display("FAIL rnd_tx_data[%0d]: got %h want %h", n, tx_data, model_tx_data()); end
            n_checks++; if (misaligned_fault !== m_fault) begin n_fail++; $display("FAIL rnd_fault[%0d]: got %b want %b", n, misaligned_fault, m_fault); end
        end
    endtask

    initial begin
        reset = 1'b1; pad_read = 1'b0; pad_write = 1'b0; address = 32'h0;
        pad_data_size = SIZE_WORD; data_out = 32'h0; tx_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_ram_directed();
        test_misaligned();
        test_rw_same();
        test_fifo_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_cycle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test by %0t, want finish", $time);
        $fatal(1, "simulation timeout");
    end

endmodule
